iris_sequencer: RTL and testbench

//  Sample-level controller for the Iris_net classifier datapath (NN_Translated + arg_max).
//  - Accepts one 4-feature sample on a valid/ready input stream.
//  - Holds the features stable, drives En/Run and waits for all four stage-ready flags.
//  - Captures the class and returns it on a valid/ready output stream.
//  - Watchdog: a hung datapath yields a flagged result instead of a stall.

---
 rtl/iris_sequencer.sv | 130 +++++++++++++
 tb/tb_iris_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iris_sequencer.sv
// Sample-level controller for the Iris_net classifier: accepts one feature vector,
// runs the datapath, collects the class and guards against a hung datapath with a watchdog.
module iris_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_x1,
  input  logic [DATA_WIDTH-1:0] s_x2,
  input  logic [DATA_WIDTH-1:0] s_x3,
  input  logic [DATA_WIDTH-1:0] s_x4,
  output logic                  nn_en,
  output logic                  nn_run,
  output logic [DATA_WIDTH-1:0] nn_x1,
  output logic [DATA_WIDTH-1:0] nn_x2,
  output logic [DATA_WIDTH-1:0] nn_x3,
  output logic [DATA_WIDTH-1:0] nn_x4,
  input  logic [1:0]            nn_yc,
  input  logic [3:0]            nn_ready,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            m_class,
  output logic                  m_timeout,
  output logic                  busy,
  output logic [CNT_W-1:0]      cnt_done,
  output logic [CNT_W-1:0]      cnt_tmo
);

  // state | meaning
  // IDLE  | waiting for a sample, s_ready high
  // START | first Run cycle, features already latched
  // WAIT  | datapath running, watchdog counting
  // OUT   | result presented until the consumer takes it
  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [WC_W-1:0] wcnt;
  logic            accept, done, expire, deliver;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    nn_en     = 1'b0;
    nn_run    = 1'b0;
    m_valid   = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    expire    = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        nn_en     = 1'b1;
        nn_run    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        nn_en  = 1'b1;
        nn_run = 1'b1;
        // first WAIT cycle ignores ready flags left over from the previous sample
        done   = (wcnt != '0) && (nn_ready == 4'hF);
        expire = !done && (wcnt == WC_LAST);
        if (done || expire) state_nxt = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nn_x1     <= '0;
      nn_x2     <= '0;
      nn_x3     <= '0;
      nn_x4     <= '0;
      wcnt      <= '0;
      m_class   <= 2'b00;
      m_timeout <= 1'b0;
      cnt_done  <= '0;
      cnt_tmo   <= '0;
    end else begin
      if (accept) begin
        nn_x1 <= s_x1;
        nn_x2 <= s_x2;
        nn_x3 <= s_x3;
        nn_x4 <= s_x4;
        wcnt  <= '0;
      end
      if (state == WAIT && wcnt != WC_LAST) wcnt <= wcnt + WC_W'(1);
      if (done) begin
        m_class   <= nn_yc;
        m_timeout <= 1'b0;
      end else if (expire) begin
        m_class   <= 2'b11;
        m_timeout <= 1'b1;
      end
      if (deliver) begin
        if (cnt_done != '1) cnt_done <= cnt_done + CNT_W'(1);
        if (m_timeout && cnt_tmo != '1) cnt_tmo <= cnt_tmo + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_iris_sequencer.sv
// Directed bench for iris_sequencer: TIMEOUT=8, CNT_W=2, datapath ready/class driven by hand.
module tb_iris_sequencer;
  localparam int DW  = 8;
  localparam int TMO = 8;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_x1 = '0, s_x2 = '0, s_x3 = '0, s_x4 = '0;
  logic          nn_en, nn_run;
  logic [DW-1:0] nn_x1, nn_x2, nn_x3, nn_x4;
  logic [1:0]    nn_yc = 2'd0;
  logic [3:0]    nn_ready = 4'h0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [1:0]    m_class;
  logic          m_timeout, busy;
  logic [CW-1:0] cnt_done, cnt_tmo;

  int total = 0;
  int passed = 0;

  iris_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_x1(s_x1), .s_x2(s_x2), .s_x3(s_x3), .s_x4(s_x4),
    .nn_en(nn_en), .nn_run(nn_run),
    .nn_x1(nn_x1), .nn_x2(nn_x2), .nn_x3(nn_x3), .nn_x4(nn_x4),
    .nn_yc(nn_yc), .nn_ready(nn_ready),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .m_timeout(m_timeout), .busy(busy),
    .cnt_done(cnt_done), .cnt_tmo(cnt_tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang want finish");
    $fatal(1);
  end

  task automatic set_x(input int a, input int b, input int c, input int d);
    s_x1 = DW'(a); s_x2 = DW'(b); s_x3 = DW'(c); s_x4 = DW'(d);
  endtask

  // Stimulus only: one full transaction, result handed back to the caller for checking.
  task automatic run_sample(input int a, input int b, input int c, input int d,
                            input logic [1:0] yc, input int dly,
                            output logic [1:0] cls, output logic tmo, output int cyc);
    set_x(a, b, c, d);
    s_valid = 1'b1;
    nn_ready = 4'h0;
    @(negedge clk);
    s_valid = 1'b0;
    cyc = 0;
    while (!m_valid && cyc < 40) begin
      if (cyc == dly) begin
        nn_ready = 4'hF;
        nn_yc = yc;
      end
      @(negedge clk);
      cyc++;
    end
    cls = m_class;
    tmo = m_timeout;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    nn_ready = 4'h0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({s_ready, nn_en, nn_run, m_valid, busy, m_timeout} !== 6'b100000) begin
      $display("FAIL reset_ctrl: got %b want 100000", {s_ready, nn_en, nn_run, m_valid, busy, m_timeout});
    end else passed++;
    total++;
    if ({m_class, cnt_done, cnt_tmo, nn_x1, nn_x2, nn_x3, nn_x4} !== '0) begin
      $display("FAIL reset_data: got class=%0d done=%0d tmo=%0d x1=%0d want all 0", m_class, cnt_done, cnt_tmo, nn_x1);
    end else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit early = 0;
    set_x(51, 35, 14, 2);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    total++;
    if ({nn_run, nn_en, s_ready, busy} !== 4'b1101) begin
      $display("FAIL single_start: got run/en/sready/busy=%b want 1101", {nn_run, nn_en, s_ready, busy});
    end else passed++;
    total++;
    if ({nn_x1, nn_x2, nn_x3, nn_x4} !== {8'd51, 8'd35, 8'd14, 8'd2}) begin
      $display("FAIL single_feat: got %0d,%0d,%0d,%0d want 51,35,14,2", nn_x1, nn_x2, nn_x3, nn_x4);
    end else passed++;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (m_valid) early = 1;
      if (i == 5) begin
        nn_ready = 4'hF;
        nn_yc = 2'd0;
      end
    end
    total++;
    if (early !== 1'b0) $display("FAIL single_early: got m_valid before completion want none");
    else passed++;
    @(negedge clk);
    total++;
    if ({m_valid, m_class, m_timeout, nn_run} !== 5'b1_00_0_0) begin
      $display("FAIL single_result: got valid=%b class=%0d tmo=%b run=%b want 1,0,0,0", m_valid, m_class, m_timeout, nn_run);
    end else passed++;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    total++;
    if ({m_valid, s_ready, cnt_done, cnt_tmo} !== {1'b0, 1'b1, 2'd1, 2'd0}) begin
      $display("FAIL single_handshake: got valid=%b sready=%b done=%0d tmo=%0d want 0,1,1,0", m_valid, s_ready, cnt_done, cnt_tmo);
    end else passed++;
  endtask

  task automatic test_stale();
    nn_yc = 2'd1;
    set_x(60, 22, 40, 10);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0) $display("FAIL stale_masked: got m_valid=%b after first WAIT cycle want 0", m_valid);
    else passed++;
    @(negedge clk);
    total++;
    if ({m_valid, m_class} !== {1'b1, 2'd1}) begin
      $display("FAIL stale_complete: got valid=%b class=%0d want 1,1", m_valid, m_class);
    end else passed++;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    nn_ready = 4'h0;
    total++;
    if (cnt_done !== 2'd2) $display("FAIL stale_cnt: got cnt_done=%0d want 2", cnt_done);
    else passed++;
  endtask

  task automatic test_timeout();
    bit early = 0;
    nn_ready = 4'h7;
    nn_yc = 2'd2;
    set_x(1, 2, 3, 4);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (m_valid) early = 1;
    end
    total++;
    if (early !== 1'b0) $display("FAIL tmo_early: got m_valid within 8 WAIT cycles want none");
    else passed++;
    @(negedge clk);
    total++;
    if ({m_valid, m_class, m_timeout, nn_run} !== 5'b1_11_1_0) begin
      $display("FAIL tmo_result: got valid=%b class=%0d tmo=%b run=%b want 1,3,1,0", m_valid, m_class, m_timeout, nn_run);
    end else passed++;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    nn_ready = 4'h0;
    total++;
    if ({cnt_done, cnt_tmo} !== {2'd3, 2'd1}) begin
      $display("FAIL tmo_cnt: got done=%0d tmo=%0d want 3,1", cnt_done, cnt_tmo);
    end else passed++;
  endtask

  task automatic test_tmo_boundary();
    nn_ready = 4'h0;
    nn_yc = 2'd2;
    set_x(7, 7, 7, 7);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) nn_ready = 4'hF;
    end
    @(negedge clk);
    total++;
    if ({m_valid, m_class, m_timeout} !== 4'b1_10_0) begin
      $display("FAIL tmo_tie: got valid=%b class=%0d tmo=%b want 1,2,0", m_valid, m_class, m_timeout);
    end else passed++;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    nn_ready = 4'h0;
    total++;
    if ({cnt_done, cnt_tmo} !== {2'd3, 2'd1}) begin
      $display("FAIL tie_cnt_sat: got done=%0d tmo=%0d want 3,1", cnt_done, cnt_tmo);
    end else passed++;
  endtask

  task automatic test_backpressure();
    bit unstable = 0;
    set_x(5, 6, 7, 8);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nn_ready = 4'hF;
    nn_yc = 2'd1;
    @(negedge clk);
    set_x(9, 9, 9, 9);
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({m_valid, m_class, s_ready, nn_run} !== 5'b1_01_0_0) unstable = 1;
      if ({nn_x1, nn_x2, nn_x3, nn_x4} !== {8'd5, 8'd6, 8'd7, 8'd8}) unstable = 1;
    end
    total++;
    if (unstable !== 1'b0) $display("FAIL bp_hold: got result/inputs disturbed under backpressure want stable");
    else passed++;
    m_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({m_valid, s_ready, busy} !== 3'b010) begin
      $display("FAIL bp_release: got valid/sready/busy=%b want 010", {m_valid, s_ready, busy});
    end else passed++;
    total++;
    if ({nn_x1, nn_x2, nn_x3, nn_x4} !== {8'd5, 8'd6, 8'd7, 8'd8}) begin
      $display("FAIL bp_no_accept: got x1=%0d want 5", nn_x1);
    end else passed++;
    s_valid = 1'b0;
    m_ready = 1'b0;
    nn_ready = 4'h0;
  endtask

  task automatic test_reset_mid();
    set_x(11, 12, 13, 14);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, nn_run} !== 2'b11) $display("FAIL mid_pre: got busy/run=%b want 11", {busy, nn_run});
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({nn_run, nn_en, m_valid, s_ready, busy} !== 5'b00010) begin
      $display("FAIL mid_reset_ctrl: got run/en/valid/sready/busy=%b want 00010", {nn_run, nn_en, m_valid, s_ready, busy});
    end else passed++;
    total++;
    if ({cnt_done, cnt_tmo, nn_x1, m_class} !== '0) begin
      $display("FAIL mid_reset_data: got done=%0d tmo=%0d x1=%0d class=%0d want 0", cnt_done, cnt_tmo, nn_x1, m_class);
    end else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cls [3];
    int acc = 0, res = 0, run_idx = -1, run_len = 0, low_len = 0, cyc = 0;
    logic prev_run = 1'b0;
    bit gap_bad = 0, order_bad = 0;
    exp_cls[0] = 2'd2; exp_cls[1] = 2'd1; exp_cls[2] = 2'd0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    set_x(20, 21, 22, 23);
    nn_ready = 4'h0;
    while (res < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (nn_run && !prev_run) begin
        run_idx++;
        if (run_idx > 0 && low_len < 2) gap_bad = 1;
        run_len = 0;
        low_len = 0;
        set_x(30 + run_idx, 31, 32, 33);
      end
      if (nn_run) run_len++;
      else low_len++;
      nn_ready = (nn_run && run_len >= 3) ? 4'hF : 4'h0;
      if (run_idx >= 0 && run_idx < 3) nn_yc = exp_cls[run_idx];
      if (m_valid) begin
        if (m_class !== exp_cls[res]) order_bad = 1;
        res++;
      end
      if (s_ready) begin
        if (acc == 3) s_valid = 1'b0;
        else acc++;
      end
      prev_run = nn_run;
    end
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b0;
    nn_ready = 4'h0;
    total++;
    if (res !== 3) $display("FAIL b2b_count: got %0d results want 3", res);
    else passed++;
    total++;
    if (order_bad !== 1'b0) $display("FAIL b2b_order: got class sequence differing from 2,1,0 want 2,1,0");
    else passed++;
    total++;
    if (gap_bad !== 1'b0) $display("FAIL b2b_run_gap: got nn_run low <2 cycles between runs want >=2");
    else passed++;
    total++;
    if ({cnt_done, cnt_tmo, busy} !== {2'd3, 2'd0, 1'b0}) begin
      $display("FAIL b2b_cnt: got done=%0d tmo=%0d busy=%b want 3,0,0", cnt_done, cnt_tmo, busy);
    end else passed++;
  endtask

  task automatic test_saturation();
    logic [1:0] cls;
    logic tmo;
    int cyc;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      run_sample(i, 2 * i, 3 * i, 4 * i, 2'(i % 3), 1 + i, cls, tmo, cyc);
      total++;
      if (cyc !== i + 2) $display("FAIL sat_latency%0d: got %0d cycles want %0d", i, cyc, i + 2);
      else passed++;
      total++;
      if ({cls, tmo} !== {2'(i % 3), 1'b0}) $display("FAIL sat_class%0d: got class=%0d tmo=%b want %0d,0", i, cls, tmo, i % 3);
      else passed++;
      total++;
      if (cnt_done !== 2'((i > 3) ? 3 : i)) $display("FAIL sat_cnt%0d: got %0d want %0d", i, cnt_done, (i > 3) ? 3 : i);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stale();
    test_timeout();
    test_tmo_boundary();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
